disp_vramctrl: RTL and testbench
================================

DISP_VRAMCTRL -- requirements
Module: disp_vramctrl

Interface
REQ-001 Parameter BURST_NUM, default 9600, SHALL give the read bursts per frame (640x480 pixels, 32-bit each, 128 B per burst).
REQ-002 Parameter BURST_LEN, default 16, SHALL give the 64-bit beats per burst; ARLEN = BURST_LEN-1.
REQ-003 Ports SHALL be:
- ACLK  in  1  clock
- ARST  in  1  reset; synchronous, active-high
- DSP_VSYNC_X  in  1  active-low VSYNC from syncgen, asynchronous to ACLK
- DISPON  in  1  display enable from register block
- DISPADDR  in  29  frame base byte address
- ARADDR  out  32  read address
- ARLEN  out  8  burst length-1
- ARVALID  out  1  address valid
- ARREADY  in  1  address accept
- RDATA  in  64  read data
- RLAST  in  1  last beat
- RVALID  in  1  data valid
- RREADY  out  1  data ready
- BUF_WREADY  in  1  disp_buffer has room for one full burst
- BUF_WDATA  out  64  pixel pair to disp_buffer
- BUF_WEN  out  1  buffer write strobe

Function
REQ-004 DSP_VSYNC_X SHALL pass a 2-flop synchronizer; a falling edge of the synchronized value SHALL give a 1-cycle vstart pulse, 3 cycles after the input edge.
REQ-005 FSM states SHALL be IDLE, AREQ, RDAT.
REQ-006 IDLE: on vstart with DISPON=1, latch DISPADDR[28:7] as base (bits [6:0] forced 0), clear burst counter, go to AREQ; vstart with DISPON=0 SHALL be ignored.
REQ-007 AREQ: ARVALID SHALL be 1 only while BUF_WREADY=1; once asserted, ARVALID and ARADDR SHALL hold until ARREADY, even if BUF_WREADY falls; on ARVALID&ARREADY go to RDAT.
REQ-008 ARADDR SHALL equal {3'b000, base + burst_count*128}; the sum is 29-bit and wraps modulo 2^29.
REQ-009 RDAT: RREADY SHALL be 1; BUF_WEN SHALL equal RVALID&RREADY in the same cycle, with BUF_WDATA=RDATA combinationally (0 cycles latency).
REQ-010 On RVALID&RLAST in RDAT: increment the burst counter; if it reaches BURST_NUM, or DISPON=0, go to IDLE; otherwise go to AREQ.
REQ-011 DISPON falling mid-frame SHALL NOT abort an issued AR or a burst in flight; no further AR SHALL be issued.
REQ-012 DISPADDR changes mid-frame SHALL take effect only at the next accepted vstart.
REQ-013 vstart outside IDLE SHALL be ignored; a frame already running completes.
REQ-014 Only one burst SHALL be outstanding at a time.

Reset
REQ-015 On ARST: state IDLE, ARVALID=0, RREADY=0, BUF_WEN=0, ARADDR=0, ARLEN=BURST_LEN-1, burst counter=0, synchronizer flops=1.
REQ-016 ARST mid-burst SHALL return to IDLE next cycle; draining the interconnect is outside this block's scope.

Configuration
REQ-017 Macro DISP_VRAMCTRL_RRESP_EN SHALL add input RRESP[1:0] and output VRAM_ERR[0:0].
- Defined: VRAM_ERR is set by any accepted beat with RRESP!=0, cleared only by ARST or by an accepted vstart.
- Undefined: neither port exists and behaviour is otherwise identical.

Structure
REQ-018 The FSM state encoding, the 128-byte burst size, and defaults for BURST_NUM/BURST_LEN SHALL live in package disp_pkg.
REQ-019 The VSYNC synchronizer/edge detector SHALL be sub-module disp_vsync_sync; everything else is flat.

Verification
REQ-020 BURST_NUM=4, DISPADDR=0x0100080, DISPON=1, VSYNC fall, ARREADY/RVALID always 1 -> ARADDR 0x0100080, 0x0100100, 0x0100180, 0x0100200; 64 BUF_WEN pulses; FSM back in IDLE.
REQ-021 BUF_WREADY=0 for 50 cycles after vstart -> ARVALID stays 0 until BUF_WREADY=1; a BUF_WREADY drop after ARVALID rises leaves ARVALID held until ARREADY.
REQ-022 DISPON cleared during beat 5 of burst 2 -> burst 2 completes (16 beats), no 3rd AR, IDLE.
REQ-023 DISPADDR=0x1FFFFF80, BURST_NUM=2 -> ARADDR 0x1FFFFF80 then 0x00000000.
REQ-024 RVALID toggling 1/0 each cycle -> BUF_WEN mirrors RVALID beat for beat, with BUF_WDATA matching RDATA each beat.
REQ-025 With DISP_VRAMCTRL_RRESP_EN, RRESP=2 on one beat -> VRAM_ERR=1 until the next accepted vstart.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display VRAM read controller.
// FSM encoding, burst geometry and parameter defaults live here.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AREQ = 2'd1,
    ST_RDAT = 2'd2
  } disp_state_e;

  localparam int DISP_BURST_NUM_DEF = 9600;
  localparam int DISP_BURST_LEN_DEF = 16;
  localparam int DISP_BURST_BYTES   = 128;
  localparam int DISP_BURST_SHIFT   = $clog2(DISP_BURST_BYTES);
  // Addresses are tracked in whole-burst units inside the 29-bit byte space.
  localparam int DISP_BLK_W         = 29 - DISP_BURST_SHIFT;

endpackage

// File: rtl/disp_vsync_sync.sv
// Two-flop synchronizer for the active-low VSYNC plus a registered
// falling-edge detector producing a one-cycle vstart pulse.
module disp_vsync_sync (
  input  logic ACLK,
  input  logic ARST,
  input  logic vsync_x,
  output logic vstart
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic vstart_q, vstart_d;

  always_comb begin
    sync1_d  = vsync_x;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    vstart_d = dly_q & ~sync2_q;
  end

  // Synchronizer idles high so that reset release never looks like a VSYNC edge.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      dly_q    <= 1'b1;
      vstart_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dly_q    <= dly_d;
      vstart_q <= vstart_d;
    end
  end

  assign vstart = vstart_q;

endmodule

// File: rtl/disp_vramctrl.sv
// Display VRAM read controller: one AXI read burst at a time per frame, data streamed to disp_buffer.
// Optional macro DISP_VRAMCTRL_RRESP_EN adds RRESP input and sticky VRAM_ERR output.
module disp_vramctrl
  import disp_pkg::*;
#(
  parameter int BURST_NUM = DISP_BURST_NUM_DEF,
  parameter int BURST_LEN = DISP_BURST_LEN_DEF
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DSP_VSYNC_X,
  input  logic        DISPON,
  input  logic [28:0] DISPADDR,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [63:0] RDATA,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
`ifdef DISP_VRAMCTRL_RRESP_EN
  input  logic [1:0]  RRESP,
  output logic [0:0]  VRAM_ERR,
`endif
  input  logic        BUF_WREADY,
  output logic [63:0] BUF_WDATA,
  output logic        BUF_WEN
);

  localparam logic [DISP_BLK_W-1:0] LAST_CNT = DISP_BLK_W'(BURST_NUM);

  disp_state_e           state_q, state_d;
  logic [DISP_BLK_W-1:0] base_q, base_d;
  logic [DISP_BLK_W-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [DISP_BLK_W-1:0] blk_addr;
  logic                  vstart;
  logic                  vstart_ok;
  logic                  unused_addr_bits;

  disp_vsync_sync u_vsync_sync (
    .ACLK    (ACLK),
    .ARST    (ARST),
    .vsync_x (DSP_VSYNC_X),
    .vstart  (vstart)
  );

  // Low address bits are dropped: every frame starts on a burst boundary.
  assign unused_addr_bits = ^DISPADDR[DISP_BURST_SHIFT-1:0];
  assign vstart_ok        = vstart & DISPON & (state_q == ST_IDLE);

  // Adding in burst units wraps exactly like the 29-bit byte sum.
  assign blk_addr  = base_q + cnt_q;
  assign ARADDR    = {3'b000, blk_addr, {DISP_BURST_SHIFT{1'b0}}};
  assign ARLEN     = 8'(BURST_LEN - 1);
  assign BUF_WEN   = RVALID & RREADY;
  assign BUF_WDATA = RDATA;

  // Handshakes: ARVALID may only rise with BUF_WREADY (and DISPON); once up,
  // pend_q keeps ARVALID/ARADDR stable until ARREADY. RREADY is high for the
  // whole RDAT state and every RVALID&RREADY beat is a buffer write.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vstart_ok) begin
          base_d  = DISPADDR[28:DISP_BURST_SHIFT];
          cnt_d   = '0;
          state_d = ST_AREQ;
        end
      end
      ST_AREQ: begin
        ARVALID = pend_q | (BUF_WREADY & DISPON);
        if (ARVALID && ARREADY) begin
          pend_d  = 1'b0;
          state_d = ST_RDAT;
        end else if (ARVALID) begin
          pend_d  = 1'b1;
        end else if (!DISPON) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDAT: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_d == LAST_CNT) || !DISPON) state_d = ST_IDLE;
          else                                state_d = ST_AREQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef DISP_VRAMCTRL_RRESP_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (vstart_ok) err_d = 1'b0;
    if (RVALID && RREADY && (RRESP != 2'b00)) err_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARST) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign VRAM_ERR = err_q;
`endif

endmodule

// File: tb/tb_disp_vramctrl.sv
// Self-checking bench for disp_vramctrl with a small AXI read slave model.
module tb_disp_vramctrl;
  import disp_pkg::*;

  localparam int BN = 4;
  localparam int BL = 16;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic        DSP_VSYNC_X;
  logic        DISPON;
  logic [28:0] DISPADDR;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [63:0] RDATA;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        BUF_WREADY;
  logic [63:0] BUF_WDATA;
  logic        BUF_WEN;
`ifdef DISP_VRAMCTRL_RRESP_EN
  logic [1:0]  RRESP;
  logic [0:0]  VRAM_ERR;
  bit          inject_err;
`endif

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  disp_vramctrl #(.BURST_NUM(BN), .BURST_LEN(BL)) dut (
    .ACLK        (ACLK),
    .ARST        (ARST),
    .DSP_VSYNC_X (DSP_VSYNC_X),
    .DISPON      (DISPON),
    .DISPADDR    (DISPADDR),
    .ARADDR      (ARADDR),
    .ARLEN       (ARLEN),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RLAST       (RLAST),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
`ifdef DISP_VRAMCTRL_RRESP_EN
    .RRESP       (RRESP),
    .VRAM_ERR    (VRAM_ERR),
`endif
    .BUF_WREADY  (BUF_WREADY),
    .BUF_WDATA   (BUF_WDATA),
    .BUF_WEN     (BUF_WEN)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_addr[$];
  int          ar_count = 0;
  int          beat_count = 0;
  bit          outstanding = 1'b0;
  bit          prev_arvalid = 1'b0;
  bit          prev_arready = 1'b0;
  logic [31:0] prev_araddr = '0;
  bit          toggle_mode = 1'b0;
  bit          arready_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_addr.size()) return got_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Expected burst addresses for one frame: base rounded down to 128 B, +128 per burst, modulo 2^29.
  task automatic push_frame(input logic [28:0] base, input int n);
    logic [28:0] a;
    for (int i = 0; i < n; i++) begin
      a = (base & 29'h1FFF_FF80) + 29'(i * 128);
      exp_q.push_back({3'b000, a});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic vsync_pulse();
    DSP_VSYNC_X = 1'b0;
    repeat (6) tick();
    DSP_VSYNC_X = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (dut.state_q == ST_IDLE && !outstanding) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for idle, got busy, expected idle", name);
    end
  endtask

  // ---------------- AXI read slave ----------------
  initial begin
    bit ar_hs_s, r_hs_s, rv_phase;
    int beats_left;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
    beats_left = 0; rv_phase = 1'b0;
`ifdef DISP_VRAMCTRL_RRESP_EN
    RRESP = 2'd0;
`endif
    forever begin
      @(negedge ACLK);
      ar_hs_s = ARVALID & ARREADY;
      r_hs_s  = RVALID & RREADY;
      @(posedge ACLK);
      #1;
      if (ARST) beats_left = 0;
      else begin
        if (r_hs_s) beats_left--;
        if (ar_hs_s) beats_left = BL;
      end
      rv_phase = ~rv_phase;
      RVALID  = (beats_left > 0) && (!toggle_mode || rv_phase);
      RLAST   = (beats_left == 1);
      RDATA   = {$urandom, $urandom};
      ARREADY = arready_en;
`ifdef DISP_VRAMCTRL_RRESP_EN
      RRESP = 2'd0;
      if (RVALID && inject_err) begin
        RRESP = 2'd2;
        inject_err = 1'b0;
      end
`endif
    end
  end

  // ---------------- per-cycle compare against protocol model ----------------
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARST) begin
        outstanding  = 1'b0;
        prev_arvalid = 1'b0;
        prev_arready = 1'b0;
        continue;
      end
      if (ARVALID && !prev_arvalid) check("arvalid_rise_wready", BUF_WREADY, 1);
      if (prev_arvalid && !prev_arready) begin
        check("arvalid_hold", ARVALID, 1);
        check("araddr_hold", ARADDR, prev_araddr);
      end
      check("rready", RREADY, outstanding);
      check("buf_wen", BUF_WEN, RVALID & outstanding);
      if (BUF_WEN) check("buf_wdata", BUF_WDATA, RDATA);
      if (ARVALID) begin
        check("one_outstanding", outstanding, 0);
        check("arlen", ARLEN, BL - 1);
      end
      if (ARVALID && ARREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ar: got ARADDR 0x%0h, expected no request", ARADDR);
        end else begin
          check("araddr", ARADDR, exp_q.pop_front());
        end
        got_addr.push_back(ARADDR);
        ar_count++;
        outstanding = 1'b1;
      end
      if (RVALID && RREADY) begin
        beat_count++;
        if (RLAST) outstanding = 1'b0;
      end
      prev_arvalid = ARVALID;
      prev_arready = ARREADY;
      prev_araddr  = ARADDR;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int ar0, beat0, seen, i;
    ARST = 1'b1; DSP_VSYNC_X = 1'b1; DISPON = 1'b0; DISPADDR = '0; BUF_WREADY = 1'b1;
`ifdef DISP_VRAMCTRL_RRESP_EN
    inject_err = 1'b0;
`endif
    repeat (3) tick();
    @(negedge ACLK);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_buf_wen", BUF_WEN, 0);
    check("rst_araddr", ARADDR, 32'h0);
    check("rst_arlen", ARLEN, 8'd15);
    check("rst_idle", dut.state_q == ST_IDLE, 1);
    tick();
    ARST = 1'b0;
    repeat (3) tick();

    // vstart with DISPON=0 is ignored
    vsync_pulse();
    repeat (10) tick();
    check("dispon0_no_ar", ar_count, 0);
    check("dispon0_idle", dut.state_q == ST_IDLE, 1);

    // Basic frame, with vstart latency, mid-frame DISPADDR change and mid-frame vstart
    DISPON = 1'b1; DISPADDR = 29'h0100080;
    push_frame(29'h0100080, BN);
    ar0 = ar_count; beat0 = beat_count; got_addr.delete();
    DSP_VSYNC_X = 1'b0;
    repeat (2) @(negedge ACLK);
    check("vstart_edge1", dut.vstart, 0);
    @(negedge ACLK);
    check("vstart_edge2", dut.vstart, 0);
    @(negedge ACLK);
    check("vstart_edge3", dut.vstart, 1);
    @(negedge ACLK);
    check("vstart_pulse_len", dut.vstart, 0);
    tick();
    DISPADDR = 29'h0200000;
    repeat (3) tick();
    DSP_VSYNC_X = 1'b1;
    repeat (5) tick();
    vsync_pulse();
    wait_idle("frame_basic", 600);
    check("basic_ar_count", ar_count - ar0, 4);
    check("basic_beats", beat_count - beat0, 64);
    check("basic_addr0", got_at(0), 32'h0100080);
    check("basic_addr1", got_at(1), 32'h0100100);
    check("basic_addr3", got_at(3), 32'h0100200);
    check("basic_exp_empty", exp_q.size(), 0);
    check("basic_idle", dut.state_q == ST_IDLE, 1);

    // BUF_WREADY gating and ARVALID hold
    DISPADDR = 29'h0000400; BUF_WREADY = 1'b0;
    push_frame(29'h0000400, BN);
    ar0 = ar_count; beat0 = beat_count; got_addr.delete();
    DSP_VSYNC_X = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (k == 6) DSP_VSYNC_X = 1'b1;
      @(negedge ACLK);
      if (ARVALID) seen++;
    end
    check("wready0_no_arvalid", seen, 0);
    check("wready0_in_areq", dut.state_q == ST_AREQ, 1);
    arready_en = 1'b0;
    repeat (2) tick();
    BUF_WREADY = 1'b1;
    for (i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (ARVALID) break;
      tick();
    end
    check("wready1_arvalid", ARVALID, 1);
    tick();
    BUF_WREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("arvalid_held_wready0", ARVALID, 1);
      check("araddr_held_wready0", ARADDR, 32'h0000400);
      tick();
    end
    arready_en = 1'b1;
    BUF_WREADY = 1'b1;
    wait_idle("frame_wready", 800);
    check("wready_ar_count", ar_count - ar0, 4);
    check("wready_beats", beat_count - beat0, 64);
    check("wready_exp_empty", exp_q.size(), 0);

    // DISPON cleared during beat 5 of burst 2
    DISPADDR = 29'h0300000;
    push_frame(29'h0300000, 2);
    ar0 = ar_count; beat0 = beat_count; got_addr.delete();
    vsync_pulse();
    for (i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (beat_count - beat0 >= 20) break;
      tick();
    end
    tick();
    DISPON = 1'b0;
    wait_idle("frame_dispon", 300);
    repeat (20) tick();
    check("dispoff_ar_count", ar_count - ar0, 2);
    check("dispoff_beats", beat_count - beat0, 32);
    check("dispoff_addr1", got_at(1), 32'h0300080);
    check("dispoff_exp_empty", exp_q.size(), 0);
    check("dispoff_idle", dut.state_q == ST_IDLE, 1);
    DISPON = 1'b1;

    // 29-bit address wrap
    DISPADDR = 29'h1FFFFF80;
    push_frame(29'h1FFFFF80, BN);
    ar0 = ar_count; beat0 = beat_count; got_addr.delete();
    vsync_pulse();
    wait_idle("frame_wrap", 600);
    check("wrap_addr0", got_at(0), 32'h1FFFFF80);
    check("wrap_addr1", got_at(1), 32'h00000000);
    check("wrap_ar_count", ar_count - ar0, 4);
    check("wrap_exp_empty", exp_q.size(), 0);

    // RVALID toggling every cycle
    toggle_mode = 1'b1;
    DISPADDR = 29'h0000000;
    push_frame(29'h0000000, BN);
    ar0 = ar_count; beat0 = beat_count; got_addr.delete();
    vsync_pulse();
    wait_idle("frame_toggle", 1200);
    check("toggle_beats", beat_count - beat0, 64);
    check("toggle_ar_count", ar_count - ar0, 4);
    toggle_mode = 1'b0;

`ifdef DISP_VRAMCTRL_RRESP_EN
    // Error response is sticky until the next accepted vstart
    DISPADDR = 29'h0001000;
    push_frame(29'h0001000, BN);
    beat0 = beat_count;
    @(negedge ACLK);
    check("err_initial", VRAM_ERR, 0);
    tick();
    vsync_pulse();
    for (i = 0; i < 200; i++) begin
      tick();
      if (beat_count - beat0 >= 3) break;
    end
    inject_err = 1'b1;
    wait_idle("frame_err", 600);
    @(negedge ACLK);
    check("err_set", VRAM_ERR, 1);
    tick();
    DISPON = 1'b0;
    vsync_pulse();
    repeat (5) tick();
    @(negedge ACLK);
    check("err_held_ignored_vstart", VRAM_ERR, 1);
    tick();
    DISPON = 1'b1;
    push_frame(29'h0001000, BN);
    vsync_pulse();
    @(negedge ACLK);
    check("err_cleared", VRAM_ERR, 0);
    tick();
    wait_idle("frame_err2", 600);
`endif

    // Reset mid-burst
    DISPADDR = 29'h0000800;
    push_frame(29'h0000800, BN);
    vsync_pulse();
    for (i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (RREADY) break;
      tick();
    end
    tick();
    ARST = 1'b1;
    tick();
    @(negedge ACLK);
    check("rst_mid_idle", dut.state_q == ST_IDLE, 1);
    check("rst_mid_rready", RREADY, 0);
    check("rst_mid_arvalid", ARVALID, 0);
    tick();
    ARST = 1'b0;
    exp_q.delete();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
